// File: rtl/adder_pipe_pkg.sv
// Shared constants for the stallable adder flow-control wrapper.
package adder_pipe_pkg;
  localparam int DATA_W = 32;
  localparam int STAGES = 4;
  localparam int CNT_W  = 16;
  localparam int OCC_W  = 3;
endpackage

// File: rtl/adder_pipe_ctrl_if.sv
// Operand and result valid/ready streams of the adder wrapper.
interface adder_pipe_ctrl_if
  import adder_pipe_pkg::*;
#(
  parameter int DATA_W = adder_pipe_pkg::DATA_W
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_cin;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_sum;
  logic              out_cout;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/pipe_stall_chain.sv
// Per-stage valid tracking with stall, stop and bubble-reset generation.
module pipe_stall_chain
  import adder_pipe_pkg::*;
#(
  parameter int STAGES       = adder_pipe_pkg::STAGES,
  parameter bit ZERO_BUBBLES = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              accept,
  input  logic              out_ready,
  output logic [STAGES-1:0] vld,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] stage_rst
);
  logic [STAGES-1:0] vld_in;
  logic [STAGES-1:0] vld_next;

  // A stage stalls only if it and every stage after it holds data and the sink is blocked.
  function automatic logic [STAGES-1:0] stall_vec(input logic [STAGES-1:0] v, input logic rdy);
    logic run;
    stall_vec = '0;
    run       = ~rdy;
    for (int k = STAGES - 1; k >= 0; k--) begin
      run          = run & v[k];
      stall_vec[k] = run;
    end
  endfunction

  assign stall    = stall_vec(vld, out_ready);
  assign vld_in   = {vld[STAGES-2:0], accept};
  assign vld_next = (stall & vld) | (~stall & vld_in);

  always_comb begin
    stage_rst = '0;
    if (rst || flush) begin
      stage_rst = '1;
    end else if (ZERO_BUBBLES) begin
      stage_rst = ~stall & ~vld_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld <= '0;
    end else begin
      vld <= vld_next;
    end
  end
endmodule

// File: rtl/adder_pipe_ctrl.sv
// Flow-control wrapper around the 4-stage stallable adder: handshakes, stage controls, counters.
module adder_pipe_ctrl
  import adder_pipe_pkg::*;
#(
  parameter int DATA_W       = adder_pipe_pkg::DATA_W,
  parameter int STAGES       = adder_pipe_pkg::STAGES,
  parameter int CNT_W        = adder_pipe_pkg::CNT_W,
  parameter bit ZERO_BUBBLES = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  adder_pipe_ctrl_if.slave  bus,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  output logic              add_cin,
  output logic [STAGES-1:0] add_stop,
  output logic [STAGES-1:0] add_rst,
  input  logic [DATA_W-1:0] add_sum,
  input  logic              add_cout,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  acc_cnt,
  output logic [CNT_W-1:0]  dlv_cnt
);
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] stall;
  logic              accept;
  logic              deliver;

  pipe_stall_chain #(
    .STAGES       (STAGES),
    .ZERO_BUBBLES (ZERO_BUBBLES)
  ) u_chain (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .accept    (accept),
    .out_ready (bus.out_ready),
    .vld       (vld),
    .stall     (stall),
    .stage_rst (add_rst)
  );

  // in_ready depends on out_ready through the stall chain, never on in_valid.
  assign bus.in_ready  = ~stall[0] & ~flush;
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = vld[STAGES-1];
  assign deliver       = bus.out_valid & bus.out_ready;

  assign add_a    = bus.in_a;
  assign add_b    = bus.in_b;
  assign add_cin  = bus.in_cin;
  assign add_stop = stall;

  assign bus.out_sum  = add_sum;
  assign bus.out_cout = add_cout;

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy = occupancy + OCC_W'(vld[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt <= '0;
      dlv_cnt <= '0;
    end else begin
      if (accept)  acc_cnt <= acc_cnt + CNT_W'(1);
      if (deliver) dlv_cnt <= dlv_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_adder_pipe_ctrl.sv
// Scoreboard bench for adder_pipe_ctrl driving a behavioural 4-stage stallable adder.
module tb_adder_pipe_ctrl;
  localparam int DW = 32;
  localparam int ST = 4;
  localparam int CW = 4;

  typedef struct packed {
    logic [DW-1:0] sum;
    logic          cout;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic [DW-1:0] add_a, add_b, add_sum;
  logic add_cin, add_cout;
  logic [ST-1:0] add_stop, add_rst;
  logic [2:0] occupancy;
  logic [CW-1:0] acc_cnt, dlv_cnt;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] va [8];
  logic [DW-1:0] vb [8];
  logic          vc [8];
  logic [DW-1:0] vs [8];
  logic          vco[8];
  exp_t cur_exp;
  exp_t sb [$];

  adder_pipe_ctrl_if #(.DATA_W(DW)) bus ();

  adder_pipe_ctrl #(
    .DATA_W(DW), .STAGES(ST), .CNT_W(CW), .ZERO_BUBBLES(1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_stop(add_stop), .add_rst(add_rst),
    .add_sum(add_sum), .add_cout(add_cout),
    .occupancy(occupancy), .acc_cnt(acc_cnt), .dlv_cnt(dlv_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural stallable adder: sum formed in stage 0, then shifted through stages 1..3.
  logic [DW:0] st_q [ST];
  always @(posedge clk) begin
    if (add_rst[0]) st_q[0] <= '0;
    else if (!add_stop[0]) st_q[0] <= {1'b0, add_a} + {1'b0, add_b} + {{DW{1'b0}}, add_cin};
    for (int k = 1; k < ST; k++) begin
      if (add_rst[k]) st_q[k] <= '0;
      else if (!add_stop[k]) st_q[k] <= st_q[k-1];
    end
  end
  assign add_sum  = st_q[ST-1][DW-1:0];
  assign add_cout = st_q[ST-1][DW];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops on every delivery, pushes on every accept, drops in-flight on rst/flush.
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got sum %0h with no result pending, expected none", bus.out_sum);
      end else begin
        e = sb.pop_front();
        chk("sb_sum", 64'(bus.out_sum), 64'(e.sum));
        chk("sb_cout", 64'(bus.out_cout), 64'(e.cout));
      end
    end
    if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) sb.push_back(cur_exp);
    if (rst || flush) sb.delete();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input int i);
    bus.in_valid = 1'b1;
    bus.in_a     = va[i];
    bus.in_b     = vb[i];
    bus.in_cin   = vc[i];
    cur_exp.sum  = vs[i];
    cur_exp.cout = vco[i];
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1; flush = 1'b0; idle(); bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rst_add_rst", 64'(add_rst), 64'hF);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_occupancy", 64'(occupancy), 0);
    chk("rst_in_ready", 64'(bus.in_ready), 1);
    chk("rst_acc_cnt", 64'(acc_cnt), 0);
    chk("rst_dlv_cnt", 64'(dlv_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    va[0] = 32'h0000_00FF; vb[0] = 32'h0000_0001; vc[0] = 0; vs[0] = 32'h0000_0100; vco[0] = 0;
    va[1] = 32'hFFFF_FFFF; vb[1] = 32'h0000_0000; vc[1] = 1; vs[1] = 32'h0000_0000; vco[1] = 1;
    va[2] = 32'h0000_0001; vb[2] = 32'h0000_0002; vc[2] = 0; vs[2] = 32'h0000_0003; vco[2] = 0;
    va[3] = 32'h8000_0000; vb[3] = 32'h8000_0000; vc[3] = 0; vs[3] = 32'h0000_0000; vco[3] = 1;
    va[4] = 32'h1234_5678; vb[4] = 32'h1111_1111; vc[4] = 1; vs[4] = 32'h2345_678A; vco[4] = 0;
    va[5] = 32'h7FFF_FFFF; vb[5] = 32'h0000_0001; vc[5] = 0; vs[5] = 32'h8000_0000; vco[5] = 0;
    va[6] = 32'hDEAD_BEEF; vb[6] = 32'h0000_0001; vc[6] = 0; vs[6] = 32'hDEAD_BEF0; vco[6] = 0;
    va[7] = 32'hFFFF_FFFF; vb[7] = 32'hFFFF_FFFF; vc[7] = 1; vs[7] = 32'hFFFF_FFFF; vco[7] = 1;
    bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 0; bus.out_ready = 1;
    cur_exp = '0;

    // Single op: latency 4, occupancy 1 for four cycles, bubble reset behind it.
    do_reset();
    step(); drive_op(0);
    @(negedge clk); chk("t1_in_ready", 64'(bus.in_ready), 1);
    step(); idle();
    @(negedge clk);
    chk("t1_occ_c1", 64'(occupancy), 1);
    chk("t1_out_valid_c1", 64'(bus.out_valid), 0);
    chk("t1_add_rst_c1", 64'(add_rst), 64'hD);
    for (int i = 2; i <= 4; i++) begin
      step();
      @(negedge clk);
      chk("t1_occ", 64'(occupancy), 1);
      chk("t1_out_valid", 64'(bus.out_valid), (i == 4) ? 64'd1 : 64'd0);
    end
    step();
    @(negedge clk); chk("t1_occ_after", 64'(occupancy), 0);

    // Full carry ripple.
    step(); drive_op(1);
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 1) idle();
      @(negedge clk);
    end
    chk("t2_out_valid", 64'(bus.out_valid), 1);
    chk("t2_out_sum", 64'(bus.out_sum), 0);
    chk("t2_out_cout", 64'(bus.out_cout), 1);
    step();
    @(negedge clk);
    chk("t2_acc_cnt", 64'(acc_cnt), 2);
    chk("t2_dlv_cnt", 64'(dlv_cnt), 2);

    // Back-pressure: fill, hold, then drain six results in order.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(); bus.out_ready = 0; drive_op(2 + i);
      @(negedge clk); chk("t3_fill_in_ready", 64'(bus.in_ready), 1);
    end
    step(); drive_op(6);
    @(negedge clk);
    chk("t3_full_in_ready", 64'(bus.in_ready), 0);
    chk("t3_full_occ", 64'(occupancy), 4);
    chk("t3_full_stop", 64'(add_stop), 64'hF);
    chk("t3_full_add_rst", 64'(add_rst), 0);
    chk("t3_hold_sum0", 64'(bus.out_sum), 64'h3);
    step();
    @(negedge clk);
    chk("t3_hold_sum1", 64'(bus.out_sum), 64'h3);
    chk("t3_hold_stop", 64'(add_stop), 64'hF);
    step(); bus.out_ready = 1;
    @(negedge clk);
    chk("t3_pass_in_ready", 64'(bus.in_ready), 1);
    chk("t3_pass_occ", 64'(occupancy), 4);
    chk("t3_pass_stop", 64'(add_stop), 0);
    step(); drive_op(7);
    @(negedge clk);
    chk("t3_pass2_in_ready", 64'(bus.in_ready), 1);
    chk("t3_pass2_occ", 64'(occupancy), 4);
    step(); idle();
    @(negedge clk); chk("t3_drain_valid", 64'(bus.out_valid), 1);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      chk("t3_drain_valid", 64'(bus.out_valid), (i < 3) ? 64'd1 : 64'd0);
    end
    chk("t3_acc_cnt", 64'(acc_cnt), 6);
    chk("t3_dlv_cnt", 64'(dlv_cnt), 6);

    // Bubble collapse: A stalls in stage 3, B advances to stage 2.
    do_reset();
    step(); bus.out_ready = 0; drive_op(3);
    @(negedge clk); chk("t4_in_ready_a", 64'(bus.in_ready), 1);
    step(); idle();
    step();
    step(); drive_op(4);
    @(negedge clk); chk("t4_in_ready_b", 64'(bus.in_ready), 1);
    step(); idle();
    @(negedge clk);
    chk("t4_stop_c4", 64'(add_stop), 64'h8);
    chk("t4_add_rst_c4", 64'(add_rst), 64'h5);
    chk("t4_occ_c4", 64'(occupancy), 2);
    step();
    step();
    @(negedge clk);
    chk("t4_occ_c6", 64'(occupancy), 2);
    chk("t4_stop_c6", 64'(add_stop), 64'hC);
    chk("t4_add_rst_c6", 64'(add_rst), 64'h3);
    chk("t4_in_ready_c6", 64'(bus.in_ready), 1);
    step(); bus.out_ready = 1;
    repeat (3) step();
    @(negedge clk);
    chk("t4_dlv_cnt", 64'(dlv_cnt), 2);

    // Flush with three ops in flight.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(); drive_op(i);
    end
    step(); drive_op(5); flush = 1;
    @(negedge clk);
    chk("t5_flush_in_ready", 64'(bus.in_ready), 0);
    chk("t5_flush_add_rst", 64'(add_rst), 64'hF);
    chk("t5_flush_occ", 64'(occupancy), 3);
    step(); flush = 0; idle();
    @(negedge clk);
    chk("t5_occ", 64'(occupancy), 0);
    chk("t5_out_valid", 64'(bus.out_valid), 0);
    chk("t5_acc_cnt", 64'(acc_cnt), 3);
    repeat (5) step();
    @(negedge clk);
    chk("t5_dlv_cnt", 64'(dlv_cnt), 0);

    // Counter wrap with 4-bit counters, then reset mid-stream.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(); drive_op(i % 8);
    end
    step(); idle();
    repeat (4) step();
    @(negedge clk);
    chk("t6_acc_wrap", 64'(acc_cnt), 1);
    chk("t6_dlv_wrap", 64'(dlv_cnt), 1);
    for (int i = 0; i < 3; i++) begin
      step(); drive_op(i);
    end
    step(); rst = 1;
    @(negedge clk); chk("t6_rst_add_rst", 64'(add_rst), 64'hF);
    step(); rst = 0; idle();
    @(negedge clk);
    chk("t6_rst_acc", 64'(acc_cnt), 0);
    chk("t6_rst_dlv", 64'(dlv_cnt), 0);
    chk("t6_rst_out_valid", 64'(bus.out_valid), 0);
    chk("t6_rst_occ", 64'(occupancy), 0);
    repeat (5) step();
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
